// File: rtl/latency_catch_pkg.sv
// Shared definitions for latency_catch_fifo: width helpers, default sizing, error codes.
// The optional same-cycle bypass is enabled by defining LATENCY_CATCH_BYPASS_EN.
package latency_catch_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

  localparam int LCF_DEPTH_DEFAULT = 32'sd4;
  localparam int LCF_CNT_W_DEFAULT = clog2(LCF_DEPTH_DEFAULT + 32'sd1);
  localparam int LCF_PTR_W_DEFAULT = clog2(LCF_DEPTH_DEFAULT);

  // Reserved for a future err_code port; err currently reports only the sticky OR.
  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_RET_NO_CREDIT = 2'd1,
    ERR_OVERFLOW      = 2'd2
  } err_code_e;

endpackage

// File: rtl/latency_catch_mem.sv
// DEPTH x WIDTH storage for latency_catch_fifo: one write port, one async read port, no reset.
module latency_catch_mem
  import latency_catch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic [clog2(DEPTH)-1:0]   i_waddr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic [clog2(DEPTH)-1:0]   i_raddr,
  output logic [WIDTH-1:0]          o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/latency_catch_fifo.sv
// Return-side catch FIFO behind a fixed-latency delay line: issues credits, absorbs stale
// returns after reset, flags protocol errors. Optional bypass: LATENCY_CATCH_BYPASS_EN.
module latency_catch_fifo
  import latency_catch_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        up_valid,
  output logic                        up_ready,
  input  logic                        pipe_valid,
  input  logic [WIDTH-1:0]            pipe_data,
  output logic                        dn_valid,
  output logic [WIDTH-1:0]            dn_data,
  input  logic                        dn_ready,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        err
);

  localparam int CNT_W = clog2(DEPTH + 32'sd1);
  localparam int PTR_W = clog2(DEPTH);
  localparam int WIN_W = clog2(LATENCY + 32'sd1);

  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr, w_rd_ptr_nxt, w_wr_ptr_nxt;
  logic [CNT_W-1:0] r_count, r_inflight, w_count_nxt, w_inflight_nxt;
  logic [WIN_W-1:0] r_win, w_win_nxt;
  logic             r_err, r_up_ready, w_err_nxt, w_up_ready_nxt;
  logic             w_win_done, w_issue, w_ret, w_ret_ok, w_empty, w_full;
  logic             w_pop, w_byp, w_byp_take, w_wr_req, w_ovf, w_wr_en;
  logic [CNT_W:0]   w_credit_sum;
  logic [WIDTH-1:0] w_rd_data;

  assign w_win_done = (r_win == {WIN_W{1'b0}});
  assign w_issue    = up_valid & r_up_ready;
  assign w_ret      = pipe_valid & w_win_done;
  assign w_ret_ok   = w_ret & (r_inflight != {CNT_W{1'b0}});
  assign w_empty    = (r_count == {CNT_W{1'b0}});
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = ~w_empty & dn_ready;
`ifdef LATENCY_CATCH_BYPASS_EN
  assign w_byp      = w_empty & w_ret_ok;
`else
  assign w_byp      = 1'b0;
`endif
  assign w_byp_take = w_byp & dn_ready;
  assign w_wr_req   = w_ret_ok & ~w_byp_take;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign w_ovf      = w_wr_req & w_full & ~w_pop;
  assign w_wr_en    = w_wr_req & ~w_ovf;

  // Next-state for counters, pointers, ignore window, credit and sticky error.
  always_comb begin
    w_count_nxt    = r_count;
    w_inflight_nxt = r_inflight;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_win_nxt      = r_win;
    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1'b1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1'b1);
      default: w_count_nxt = r_count;
    endcase
    case ({w_issue, w_ret_ok})
      2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1'b1);
      2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1'b1);
      default: w_inflight_nxt = r_inflight;
    endcase
    if (w_wr_en) begin
      w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 32'sd1)) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1'b1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 32'sd1)) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1'b1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    if (w_win_done) begin
      w_win_nxt = r_win;
    end else begin
      w_win_nxt = r_win - WIN_W'(1'b1);
    end
    w_credit_sum   = {1'b0, w_inflight_nxt} + {1'b0, w_count_nxt};
    w_up_ready_nxt = (w_win_nxt == {WIN_W{1'b0}}) && (w_credit_sum < (CNT_W + 1)'(DEPTH));
    w_err_nxt      = r_err | (w_ret & ~w_ret_ok) | w_ovf;
  end

  // State registers; the window reloads on every reset to swallow stale delay-line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= {CNT_W{1'b0}};
      r_inflight <= {CNT_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_win      <= WIN_W'(LATENCY);
      r_err      <= 1'b0;
      r_up_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_win      <= w_win_nxt;
      r_err      <= w_err_nxt;
      r_up_ready <= w_up_ready_nxt;
    end
  end

  latency_catch_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (pipe_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Show-ahead head; the bypass presents a return directly when nothing is queued.
  always_comb begin
    dn_valid = ~w_empty;
    dn_data  = {WIDTH{1'b0}};
    if (w_byp) begin
      dn_valid = 1'b1;
      dn_data  = pipe_data;
    end else if (!w_empty) begin
      dn_data  = w_rd_data;
    end else begin
      dn_data  = {WIDTH{1'b0}};
    end
  end

  assign up_ready = r_up_ready;
  assign count    = r_count;
  assign err      = r_err;

endmodule

// File: tb/tb_latency_catch_fifo.sv
// Directed, table-driven bench for latency_catch_fifo (DEPTH=4, LATENCY=3); the delay line
// is modelled by hand. Expectations follow LATENCY_CATCH_BYPASS_EN when it is defined.
module tb_latency_catch_fifo;

`ifdef LATENCY_CATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, up_valid, up_ready, pipe_valid, dn_valid, dn_ready, err;
  logic [31:0] pipe_data, dn_data;
  logic [2:0]  count;

  latency_catch_fifo #(.WIDTH(32), .DEPTH(4), .LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .dn_valid(dn_valid),
    .dn_data(dn_data), .dn_ready(dn_ready), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic uv; logic pv; logic [31:0] pd; logic dr;
    logic e_ur; logic e_dv; logic [31:0] e_dd; logic [2:0] e_cnt; logic e_err;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0, nmis = 0;
  int   b_lo, b_hi, e_lo, e_hi, d_lo, d_hi, r_lo, r_hi, a_lo, a_hi;

  function automatic vec_t mk(logic uv, logic pv, logic [31:0] pd, logic dr,
                              logic ur, logic dv, logic [31:0] dd, logic [2:0] cnt, logic er);
    vec_t v;
    v.uv = uv; v.pv = pv; v.pd = pd; v.dr = dr;
    v.e_ur = ur; v.e_dv = dv; v.e_dd = dd; v.e_cnt = cnt; v.e_err = er;
    return v;
  endfunction

  task automatic check_out(input string name, input logic ur, input logic dv,
                           input logic [31:0] dd, input logic [2:0] cnt, input logic er);
    nvec++;
    if (up_ready !== ur || dn_valid !== dv || dn_data !== dd || count !== cnt || err !== er) begin
      nmis++;
      $display("FAIL %s: got ur=%b dv=%b dd=%h cnt=%0d err=%b, want ur=%b dv=%b dd=%h cnt=%0d err=%b",
               name, up_ready, dn_valid, dn_data, count, err, ur, dv, dd, cnt, er);
    end
  endtask

  // Called at a negedge: drive, settle, compare, advance one cycle.
  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      up_valid = tbl[i].uv; pipe_valid = tbl[i].pv; pipe_data = tbl[i].pd; dn_ready = tbl[i].dr;
      #1;
      check_out($sformatf("vec%0d", i), tbl[i].e_ur, tbl[i].e_dv, tbl[i].e_dd, tbl[i].e_cnt, tbl[i].e_err);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        dl_v [3];
    logic [31:0] dl_d [3];
    logic        issue;
    int          tx, rx;

    // fill + credit exhaustion + single pop + drain
    b_lo = tbl.size();
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 32'hA0, 0, 1, BYP, BYP ? 32'hA0 : 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, 32'hA1, 0, 0, 1, 32'hA0, 1, 0));
    tbl.push_back(mk(1, 1, 32'hA2, 0, 0, 1, 32'hA0, 2, 0));
    tbl.push_back(mk(1, 1, 32'hA3, 0, 0, 1, 32'hA0, 3, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 32'hA0, 4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'hA1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'hA1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'hA2, 2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'hA3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    b_hi = tbl.size();
    // empty FIFO, return 0x55 with consumer ready
    e_lo = tbl.size();
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'h55, 1, 1, BYP, BYP ? 32'h55 : 32'h0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, !BYP, BYP ? 32'h0 : 32'h55, BYP ? 3'd0 : 3'd1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    e_hi = tbl.size();
    // build count=2 with 2 in flight before a mid-operation reset
    d_lo = tbl.size();
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hB0, 0, 1, BYP, BYP ? 32'hB0 : 32'h0, 0, 0));
    tbl.push_back(mk(1, 1, 32'hB1, 0, 1, 1, 32'hB0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 32'hB0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB0, 2, 0));
    d_hi = tbl.size();
    // stale return inside the window after that reset
    r_lo = tbl.size();
    tbl.push_back(mk(0, 1, 32'hC1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    r_hi = tbl.size();
    // pipe_valid held for 5 cycles after reset: 3 ignored, then returns without credit
    a_lo = tbl.size();
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 32'hEE, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hEE, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 32'hEE, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    a_hi = tbl.size();

    rst_n = 1'b0; up_valid = 1'b0; pipe_valid = 1'b0; pipe_data = 32'h0; dn_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    check_out("reset", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    run_range(b_lo, b_hi);
    run_range(e_lo, e_hi);
    run_range(d_lo, d_hi);

    // asynchronous reset in mid-cycle while a stale return is on the pipe
    pipe_valid = 1'b1; pipe_data = 32'hC0; up_valid = 1'b0; dn_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 1'b0, 1'b0, 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_range(r_lo, r_hi);

    // streaming 0x00..0x1F through a modelled 3-cycle delay line
    for (int i = 0; i < 3; i++) begin dl_v[i] = 1'b0; dl_d[i] = 32'h0; end
    tx = 0; rx = 0;
    for (int cyc = 0; cyc < 400 && rx < 32; cyc++) begin
      pipe_valid = dl_v[2]; pipe_data = dl_d[2];
      up_valid = (tx < 32); dn_ready = 1'b1;
      #1;
      issue = up_valid & up_ready;
      if (dn_valid) begin
        nvec++;
        if (dn_data !== 32'(rx)) begin
          nmis++;
          $display("FAIL stream%0d: got dn_data=%h, want %h", rx, dn_data, 32'(rx));
        end
        rx++;
      end
      @(posedge clk);
      dl_v[2] = dl_v[1]; dl_d[2] = dl_d[1];
      dl_v[1] = dl_v[0]; dl_d[1] = dl_d[0];
      dl_v[0] = issue;   dl_d[0] = 32'(tx);
      if (issue) tx++;
      @(negedge clk);
    end
    up_valid = 1'b0; pipe_valid = 1'b0; dn_ready = 1'b0;
    nvec++;
    if (rx != 32) begin
      nmis++;
      $display("FAIL stream_done: got %0d outputs, want 32", rx);
    end
    #1 check_out("stream_end", 1'b1, 1'b0, 32'h0, 3'd0, 1'b0);
    @(negedge clk);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_range(a_lo, a_hi);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
